id_stage_pipe: RTL and testbench

//  Parametrised decode stage: register file, load-use hazard unit and ID/EX pipeline register.

---
 rtl/id_stage_pipe.sv | 221 ++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------------------------
// id_stage_pipe
//
// Decode stage of the in-order pipeline. It contains the architectural register file, the
// load-use hazard unit and the ID/EX pipeline register. It takes the decoded fields held in
// IF/ID and hands a registered instruction to EX one cycle later.
//
// Ports
//   clk, rstb          clock and synchronous active-low reset
//   IfId_*             decoded instruction held in IF/ID (valid, pc, imm, rs1/rs2 + read flags,
//                      rd, RegWrite/MemRead/MemWrite, remaining control bundle)
//   Ex_IdExFlush       kill the instruction entering ID/EX (taken branch/jump in EX)
//   Ex_Stall           EX cannot accept; ID/EX and everything upstream hold
//   MemWb_RegWrite,
//   MemWb_RegRd,
//   Wb_RegWData        register file write port (write-back)
//   Id_PcWrite,
//   Id_IfIdWrite       upstream advance enables (low while stalling)
//   IdEx_*             contents of the ID/EX register
//
// Parameters
//   XLEN               datapath width
//   NREG               register count (power of two); x0 is hard-wired to zero
//   CTRL_W             width of the side-effect-free control bundle
//   LOAD_BUBBLES       bubbles inserted per load-use hazard, legal 1..3
//   WB_BYPASS          1: a same-cycle write-back is visible on register reads
// ---------------------------------------------------------------------------------------------
module id_stage_pipe #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NREG         = 32,
  parameter int unsigned CTRL_W       = 8,
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter bit          WB_BYPASS    = 1'b1,
  localparam int unsigned AW          = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rstb,
  // IF/ID inputs
  input  logic              IfId_Valid,
  input  logic [XLEN-1:0]   IfId_Pc,
  input  logic [XLEN-1:0]   IfId_Imm,
  input  logic [AW-1:0]     IfId_Rs1,
  input  logic [AW-1:0]     IfId_Rs2,
  input  logic              IfId_Rs1Read,
  input  logic              IfId_Rs2Read,
  input  logic [AW-1:0]     IfId_Rd,
  input  logic              IfId_RegWrite,
  input  logic              IfId_MemRead,
  input  logic              IfId_MemWrite,
  input  logic [CTRL_W-1:0] IfId_Ctrl,
  // EX feedback
  input  logic              Ex_IdExFlush,
  input  logic              Ex_Stall,
  // write-back port
  input  logic              MemWb_RegWrite,
  input  logic [AW-1:0]     MemWb_RegRd,
  input  logic [XLEN-1:0]   Wb_RegWData,
  // upstream enables
  output logic              Id_PcWrite,
  output logic              Id_IfIdWrite,
  // ID/EX register
  output logic              IdEx_Valid,
  output logic [XLEN-1:0]   IdEx_Pc,
  output logic [XLEN-1:0]   IdEx_Imm,
  output logic [XLEN-1:0]   IdEx_RegDataA,
  output logic [XLEN-1:0]   IdEx_RegDataB,
  output logic [AW-1:0]     IdEx_Rs1,
  output logic [AW-1:0]     IdEx_Rs2,
  output logic [AW-1:0]     IdEx_RegRd,
  output logic              IdEx_RegWrite,
  output logic              IdEx_MemRead,
  output logic              IdEx_MemWrite,
  output logic [CTRL_W-1:0] IdEx_Ctrl
);

  // Counter reload value: the detecting cycle is itself the first bubble, so the counter only
  // has to cover the remaining LOAD_BUBBLES-1 cycles.
  localparam logic [1:0] BubbleInit = 2'(LOAD_BUBBLES - 1);

  // -------------------------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------------------------
  logic [XLEN-1:0] r_regs [NREG];
  logic            w_wb_en;
  logic [XLEN-1:0] w_rdata_a;
  logic [XLEN-1:0] w_rdata_b;

  assign w_wb_en = MemWb_RegWrite && (MemWb_RegRd != '0);

  always_ff @(posedge clk) begin
    if (!rstb) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_en) begin
      // Never gated by stall or flush: the write-back instruction is already committed.
      r_regs[MemWb_RegRd] <= Wb_RegWData;
    end
  end

  always_comb begin
    w_rdata_a = r_regs[IfId_Rs1];
    if (IfId_Rs1 == '0) begin
      w_rdata_a = '0;
    end else if (WB_BYPASS && w_wb_en && (MemWb_RegRd == IfId_Rs1)) begin
      w_rdata_a = Wb_RegWData;
    end
  end

  always_comb begin
    w_rdata_b = r_regs[IfId_Rs2];
    if (IfId_Rs2 == '0) begin
      w_rdata_b = '0;
    end else if (WB_BYPASS && w_wb_en && (MemWb_RegRd == IfId_Rs2)) begin
      w_rdata_b = Wb_RegWData;
    end
  end

  // -------------------------------------------------------------------------------------------
  // Load-use hazard unit
  // -------------------------------------------------------------------------------------------
  logic       r_valid;
  logic       r_mem_read;
  logic [AW-1:0] r_rd;
  logic [1:0] r_cnt;
  logic [1:0] w_cnt_next;
  logic       w_src_match;
  logic       w_lu;
  logic       w_stall_lu;

  assign w_src_match = (IfId_Rs1Read && (IfId_Rs1 == r_rd)) ||
                       (IfId_Rs2Read && (IfId_Rs2 == r_rd));
  assign w_lu        = IfId_Valid && r_valid && r_mem_read && (r_rd != '0) && w_src_match;
  assign w_stall_lu  = w_lu || (r_cnt != 2'd0);

  // A flush removes the load's consumer anyway, so it also cancels the pending bubbles.
  assign Id_PcWrite   = Ex_IdExFlush || !(w_stall_lu || Ex_Stall);
  assign Id_IfIdWrite = Id_PcWrite;

  always_comb begin
    w_cnt_next = r_cnt;
    if (Ex_IdExFlush) begin
      w_cnt_next = 2'd0;
    end else if (!Ex_Stall) begin
      if (w_lu) begin
        w_cnt_next = BubbleInit;
      end else if (r_cnt != 2'd0) begin
        w_cnt_next = r_cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_cnt <= 2'd0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  // -------------------------------------------------------------------------------------------
  // ID/EX pipeline register
  // -------------------------------------------------------------------------------------------
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_imm;
  logic [XLEN-1:0]   r_data_a;
  logic [XLEN-1:0]   r_data_b;
  logic [AW-1:0]     r_rs1;
  logic [AW-1:0]     r_rs2;
  logic              r_reg_write;
  logic              r_mem_write;
  logic [CTRL_W-1:0] r_ctrl;
  logic              w_bubble;

  // Flush and bubble both load the payload but clear every field with a side effect.
  assign w_bubble = Ex_IdExFlush || w_stall_lu || !IfId_Valid;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_imm       <= '0;
      r_data_a    <= '0;
      r_data_b    <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_ctrl      <= '0;
    end else if (Ex_IdExFlush || !Ex_Stall) begin
      r_pc        <= IfId_Pc;
      r_imm       <= IfId_Imm;
      r_data_a    <= w_rdata_a;
      r_data_b    <= w_rdata_b;
      r_rs1       <= IfId_Rs1;
      r_rs2       <= IfId_Rs2;
      r_rd        <= IfId_Rd;
      r_ctrl      <= IfId_Ctrl;
      r_valid     <= !w_bubble;
      r_reg_write <= !w_bubble && IfId_RegWrite;
      r_mem_read  <= !w_bubble && IfId_MemRead;
      r_mem_write <= !w_bubble && IfId_MemWrite;
    end
  end

  assign IdEx_Valid    = r_valid;
  assign IdEx_Pc       = r_pc;
  assign IdEx_Imm      = r_imm;
  assign IdEx_RegDataA = r_data_a;
  assign IdEx_RegDataB = r_data_b;
  assign IdEx_Rs1      = r_rs1;
  assign IdEx_Rs2      = r_rs2;
  assign IdEx_RegRd    = r_rd;
  assign IdEx_RegWrite = r_reg_write;
  assign IdEx_MemRead  = r_mem_read;
  assign IdEx_MemWrite = r_mem_write;
  assign IdEx_Ctrl     = r_ctrl;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: two instances (LOAD_BUBBLES 1 and 3) share the same stimulus and are
// each tracked by an instruction-level reference model.
module tb_id_stage_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstb;
  logic        ifid_valid;
  logic [31:0] ifid_pc, ifid_imm;
  logic [4:0]  rs1, rs2, rd;
  logic        rs1read, rs2read, regwrite, memread, memwrite;
  logic [7:0]  ctrl;
  logic        flush, stall, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic [1:0]       pcw, ifidw, o_valid, o_rw, o_mr, o_mw;
  logic [1:0][31:0] o_pc, o_imm, o_a, o_b;
  logic [1:0][4:0]  o_rs1, o_rs2, o_rd;
  logic [1:0][7:0]  o_ctrl;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    id_stage_pipe #(.LOAD_BUBBLES(g == 0 ? 1 : 3)) u_dut (
      .clk           (clk),
      .rstb          (rstb),
      .IfId_Valid    (ifid_valid),
      .IfId_Pc       (ifid_pc),
      .IfId_Imm      (ifid_imm),
      .IfId_Rs1      (rs1),
      .IfId_Rs2      (rs2),
      .IfId_Rs1Read  (rs1read),
      .IfId_Rs2Read  (rs2read),
      .IfId_Rd       (rd),
      .IfId_RegWrite (regwrite),
      .IfId_MemRead  (memread),
      .IfId_MemWrite (memwrite),
      .IfId_Ctrl     (ctrl),
      .Ex_IdExFlush  (flush),
      .Ex_Stall      (stall),
      .MemWb_RegWrite(wb_we),
      .MemWb_RegRd   (wb_rd),
      .Wb_RegWData   (wb_data),
      .Id_PcWrite    (pcw[g]),
      .Id_IfIdWrite  (ifidw[g]),
      .IdEx_Valid    (o_valid[g]),
      .IdEx_Pc       (o_pc[g]),
      .IdEx_Imm      (o_imm[g]),
      .IdEx_RegDataA (o_a[g]),
      .IdEx_RegDataB (o_b[g]),
      .IdEx_Rs1      (o_rs1[g]),
      .IdEx_Rs2      (o_rs2[g]),
      .IdEx_RegRd    (o_rd[g]),
      .IdEx_RegWrite (o_rw[g]),
      .IdEx_MemRead  (o_mr[g]),
      .IdEx_MemWrite (o_mw[g]),
      .IdEx_Ctrl     (o_ctrl[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (dut%0d) at %0t: got %h expected %h", nm, d, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, imm, a, b;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mr, mw;
    logic [7:0]  ctrl;
  } idex_t;

  logic [31:0] m_regs [2][32];
  idex_t       m_ix   [2];
  int          m_left [2];   // bubbles still owed after the detecting cycle

  function automatic int bubbles(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] m_read(int d, logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_we && wb_rd == a) return wb_data;
    return m_regs[d][a];
  endfunction

  function automatic logic m_lu(int d);
    return ifid_valid && m_ix[d].valid && m_ix[d].mr && m_ix[d].rd != 5'd0 &&
           ((rs1read && rs1 == m_ix[d].rd) || (rs2read && rs2 == m_ix[d].rd));
  endfunction

  function automatic logic m_pcw(int d);
    return flush || !(m_lu(d) || m_left[d] != 0 || stall);
  endfunction

  task automatic m_edge();
    for (int d = 0; d < 2; d++) begin
      idex_t nx, fresh;
      int    nl;
      logic  lu, busy;
      lu   = m_lu(d);
      busy = lu || m_left[d] != 0;
      nx   = m_ix[d];
      nl   = m_left[d];
      fresh = '{valid: 1'b1, pc: ifid_pc, imm: ifid_imm, a: m_read(d, rs1), b: m_read(d, rs2),
                rs1: rs1, rs2: rs2, rd: rd, rw: regwrite, mr: memread, mw: memwrite, ctrl: ctrl};
      if (!rstb) begin
        nx = '0;
        nl = 0;
        for (int r = 0; r < 32; r++) m_regs[d][r] = 32'd0;
      end else begin
        if (flush) begin
          nx = fresh;
          nx.valid = 1'b0; nx.rw = 1'b0; nx.mr = 1'b0; nx.mw = 1'b0;
          nl = 0;
        end else if (!stall) begin
          nl = lu ? bubbles(d) - 1 : (nl > 0 ? nl - 1 : 0);
          nx = fresh;
          if (busy || !ifid_valid) begin
            nx.valid = 1'b0; nx.rw = 1'b0; nx.mr = 1'b0; nx.mw = 1'b0;
          end
        end
        if (wb_we && wb_rd != 5'd0) m_regs[d][wb_rd] = wb_data;
      end
      m_ix[d]   = nx;
      m_left[d] = nl;
    end
  endtask

  // Combinational outputs checked mid-cycle, before the edge.
  task automatic pre();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("pcwrite", d, 32'(pcw[d]), 32'(m_pcw(d)));
      chk("ifidwrite", d, 32'(ifidw[d]), 32'(m_pcw(d)));
    end
  endtask

  // Edge, model update, then registered outputs checked just after the edge.
  task automatic post();
    @(posedge clk);
    m_edge();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("valid", d, 32'(o_valid[d]), 32'(m_ix[d].valid));
      chk("pc", d, o_pc[d], m_ix[d].pc);
      chk("imm", d, o_imm[d], m_ix[d].imm);
      chk("dataA", d, o_a[d], m_ix[d].a);
      chk("dataB", d, o_b[d], m_ix[d].b);
      chk("rs1", d, 32'(o_rs1[d]), 32'(m_ix[d].rs1));
      chk("rs2", d, 32'(o_rs2[d]), 32'(m_ix[d].rs2));
      chk("rd", d, 32'(o_rd[d]), 32'(m_ix[d].rd));
      chk("regwrite", d, 32'(o_rw[d]), 32'(m_ix[d].rw));
      chk("memread", d, 32'(o_mr[d]), 32'(m_ix[d].mr));
      chk("memwrite", d, 32'(o_mw[d]), 32'(m_ix[d].mw));
      chk("ctrl", d, 32'(o_ctrl[d]), 32'(m_ix[d].ctrl));
    end
  endtask

  task automatic nop();
    rstb = 1'b1; ifid_valid = 1'b0; ifid_pc = 32'd0; ifid_imm = 32'd0;
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; rs1read = 1'b0; rs2read = 1'b0;
    regwrite = 1'b0; memread = 1'b0; memwrite = 1'b0; ctrl = 8'd0;
    flush = 1'b0; stall = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
  endtask

  task automatic set_lw();
    nop();
    ifid_valid = 1'b1; ifid_pc = 32'h40; memread = 1'b1; regwrite = 1'b1;
    rd = 5'd5; rs1 = 5'd1; rs1read = 1'b1; ctrl = 8'h11;
  endtask

  task automatic set_add();
    nop();
    ifid_valid = 1'b1; ifid_pc = 32'h44; rs1 = 5'd5; rs1read = 1'b1;
    rs2 = 5'd2; rs2read = 1'b1; rd = 5'd6; regwrite = 1'b1; ctrl = 8'h22;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic [4:0]  r1, r2;
    logic [31:0] ea, eb;
  } vec_t;
  vec_t tbl [8];

  initial begin
    tbl[0] = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd0,  5'd7,  32'h0,        32'hDEADBEEF};
    tbl[1] = '{1'b1, 5'd0,  32'h00001234, 5'd0,  5'd7,  32'h0,        32'hDEADBEEF};
    tbl[2] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  32'hDEADBEEF, 32'h0};
    tbl[3] = '{1'b1, 5'd3,  32'h000000A5, 5'd3,  5'd7,  32'h000000A5, 32'hDEADBEEF};
    tbl[4] = '{1'b1, 5'd7,  32'h11112222, 5'd7,  5'd3,  32'h11112222, 32'h000000A5};
    tbl[5] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h11112222, 32'h11112222};
    tbl[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h0};
    tbl[7] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd0,  32'hFFFFFFFF, 32'h0};

    for (int d = 0; d < 2; d++) begin
      m_ix[d] = '0; m_left[d] = 0;
      for (int r = 0; r < 32; r++) m_regs[d][r] = 32'd0;
    end

    // Reset with a live instruction presented.
    set_add();
    rstb = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      m_edge();
      #1;
      for (int d = 0; d < 2; d++) begin
        chk("rst_valid", d, 32'(o_valid[d]), 32'd0);
        chk("rst_pc", d, o_pc[d], 32'd0);
        chk("rst_ctrl", d, 32'(o_ctrl[d]), 32'd0);
      end
    end

    // Register file and write-back bypass table.
    for (int i = 0; i < 8; i++) begin
      nop();
      ifid_valid = 1'b1; ifid_pc = 32'h100 + 32'(i * 4); rs1read = 1'b1; rs2read = 1'b1;
      rs1 = tbl[i].r1; rs2 = tbl[i].r2;
      wb_we = tbl[i].we; wb_rd = tbl[i].wrd; wb_data = tbl[i].wd;
      pre();
      post();
      for (int d = 0; d < 2; d++) begin
        chk("tbl_dataA", d, o_a[d], tbl[i].ea);
        chk("tbl_dataB", d, o_b[d], tbl[i].eb);
      end
    end

    // Load-use: 1 bubble on dut0, 3 bubbles on dut1.
    set_lw();  pre(); post();
    set_add(); pre();
    chk("lu_pcw_c0", 0, 32'(pcw[0]), 32'd0);
    chk("lu_pcw_c0", 1, 32'(pcw[1]), 32'd0);
    post();
    chk("lu_valid_e0", 0, 32'(o_valid[0]), 32'd0);
    chk("lu_valid_e0", 1, 32'(o_valid[1]), 32'd0);
    pre();
    chk("lu_pcw_c1", 0, 32'(pcw[0]), 32'd1);
    chk("lu_pcw_c1", 1, 32'(pcw[1]), 32'd0);
    post();
    chk("lu_valid_e1", 0, 32'(o_valid[0]), 32'd1);
    chk("lu_rd_e1", 0, 32'(o_rd[0]), 32'd6);
    chk("lu_valid_e1", 1, 32'(o_valid[1]), 32'd0);
    pre();
    chk("lu_pcw_c2", 1, 32'(pcw[1]), 32'd0);
    post();
    chk("lu_valid_e2", 1, 32'(o_valid[1]), 32'd0);
    pre();
    chk("lu_pcw_c3", 1, 32'(pcw[1]), 32'd1);
    post();
    chk("lu_valid_e3", 1, 32'(o_valid[1]), 32'd1);
    chk("lu_pc_e3", 1, o_pc[1], 32'h44);

    // Flush while dut1 still owes one bubble.
    set_lw();  pre(); post();
    set_add(); pre(); post();
    pre(); post();
    flush = 1'b1;
    pre();
    chk("fl_pcw", 1, 32'(pcw[1]), 32'd1);
    post();
    chk("fl_valid", 1, 32'(o_valid[1]), 32'd0);
    flush = 1'b0;
    pre();
    chk("fl_pcw_after", 1, 32'(pcw[1]), 32'd1);
    post();
    chk("fl_valid_after", 1, 32'(o_valid[1]), 32'd1);
    chk("fl_rd_after", 1, 32'(o_rd[1]), 32'd6);

    // EX stall held three cycles while IF/ID inputs change.
    nop();
    ifid_valid = 1'b1; ifid_pc = 32'h100; regwrite = 1'b1; rd = 5'd9;
    pre(); post();
    for (int k = 0; k < 3; k++) begin
      stall = 1'b1;
      ifid_pc = 32'h200 + 32'(k * 32'h100);
      ifid_imm = $urandom; ctrl = 8'($urandom);
      pre();
      for (int d = 0; d < 2; d++) chk("st_pcw", d, 32'(pcw[d]), 32'd0);
      post();
      for (int d = 0; d < 2; d++) chk("st_pc_hold", d, o_pc[d], 32'h100);
    end
    stall = 1'b0;
    pre();
    post();
    for (int d = 0; d < 2; d++) begin
      chk("st_release_pc", d, o_pc[d], 32'h400);
      chk("st_release_valid", d, 32'(o_valid[d]), 32'd1);
    end

    // Randomised traffic against the model.
    for (int c = 0; c < 800; c++) begin
      rstb       = ($urandom_range(0, 99) != 0);
      ifid_valid = ($urandom_range(0, 3) != 0);
      ifid_pc    = $urandom;
      ifid_imm   = $urandom;
      rs1        = 5'($urandom_range(0, 7));
      rs2        = 5'($urandom_range(0, 7));
      rd         = 5'($urandom_range(0, 7));
      rs1read    = 1'($urandom_range(0, 1));
      rs2read    = 1'($urandom_range(0, 1));
      regwrite   = 1'($urandom_range(0, 1));
      memread    = ($urandom_range(0, 2) == 0);
      memwrite   = 1'($urandom_range(0, 1));
      ctrl       = 8'($urandom);
      flush      = ($urandom_range(0, 9) == 0);
      stall      = ($urandom_range(0, 5) == 0);
      wb_we      = 1'($urandom_range(0, 1));
      wb_rd      = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      pre();
      post();
    end

    // Reset again with live input, then every register must read back as zero.
    set_add();
    rstb = 1'b0;
    pre(); post();
    pre(); post();
    for (int r = 1; r < 32; r++) begin
      nop();
      ifid_valid = 1'b1; rs1 = 5'(r); rs2 = 5'(r); rs1read = 1'b0; rs2read = 1'b0;
      pre();
      post();
      chk("rst_reg_a", 0, o_a[0], 32'd0);
      chk("rst_reg_b", 1, o_b[1], 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
